// File: rtl/pipelined_decode_stage.sv
// RV32 ID stage: decode, register file with write-through, load-use bubble, flush.
// Optional stall/flush performance counters under DECODE_PERF_CNT_EN.
module pipelined_decode_stage #(
  parameter  int XLEN      = 32,
  parameter  int IMM_WIDTH = 64,
  parameter  int NUM_REGS  = 32,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  input  logic [XLEN-1:0]      in_pc_value,
  input  logic                 flush,
  input  logic                 need_to_write,
  input  logic [REG_AW-1:0]    reg_write_dest,
  input  logic [XLEN-1:0]      reg_write_dest_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc_value,
  output logic [XLEN-1:0]      first_reg,
  output logic [XLEN-1:0]      second_reg,
  output logic [IMM_WIDTH-1:0] sign_extended,
  output logic [REG_AW-1:0]    reg_write_target,
  output logic                 reg_write,
  output logic                 reg_write_from_load,
  output logic                 is_branch,
  output logic                 is_jump,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ALU_src,
  output logic                 illegal,
  output logic [2:0]           ALU_op_base,
`ifdef DECODE_PERF_CNT_EN
  output logic [6:0]           ALU_op_ext,
  output logic [31:0]          stall_count,
  output logic [31:0]          flush_count
`else
  output logic [6:0]           ALU_op_ext
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1v;
    logic [XLEN-1:0]      rs2v;
    logic [IMM_WIDTH-1:0] imm;
    logic [REG_AW-1:0]    rd;
    logic                 wr;
    logic                 ld;
    logic                 br;
    logic                 jmp;
    logic                 mrd;
    logic                 mwr;
    logic                 src;
    logic                 ill;
    logic [2:0]           f3;
    logic [6:0]           f7;
  } bundle_t;

  logic [XLEN-1:0] regs [NUM_REGS];
  bundle_t held;
  bundle_t dec;

  logic [6:0]        op;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [31:0]       imm32;
  logic is_r, is_i, is_s, is_b, is_u, is_j, is_ld, is_sys;
  logic legal, use_rs1, use_rs2;
  logic hazard, accept;

  assign op  = instruction[6:0];
  assign rs1 = REG_AW'(instruction[19:15]);
  assign rs2 = REG_AW'(instruction[24:20]);
  assign rd  = REG_AW'(instruction[11:7]);

  assign is_r   = op == 7'b0110011;
  assign is_i   = op inside {7'b0010011, 7'b0000011, 7'b1100111};
  assign is_s   = op == 7'b0100011;
  assign is_b   = op == 7'b1100011;
  assign is_u   = op inside {7'b0110111, 7'b0010111};
  assign is_j   = op == 7'b1101111;
  assign is_ld  = op == 7'b0000011;
  assign is_sys = op inside {7'b1110011, 7'b0001111};
  assign legal  = (instruction[1:0] == 2'b11) &
                  (is_r | is_i | is_s | is_b | is_u | is_j | is_sys);

  assign use_rs1 = !(is_u | is_j);
  assign use_rs2 = is_r | is_s | is_b;

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_i: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      is_s: imm32 = {{20{instruction[31]}}, instruction[31:25],
                     instruction[11:7]};
      is_b: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
      is_u: imm32 = {instruction[31:12], 12'b0};
      is_j: imm32 = {{11{instruction[31]}}, instruction[31],
                     instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Operand read with same-cycle WB forwarding; x0 is hardwired.
  always_comb begin
    dec      = '0;
    dec.pc   = in_pc_value;
    dec.imm  = IMM_WIDTH'($signed(imm32));
    dec.rd   = rd;
    dec.wr   = legal & (is_r | is_i | is_u | is_j) & (rd != '0);
    dec.ld   = is_ld;
    dec.br   = is_b;
    dec.jmp  = is_j | (op == 7'b1100111);
    dec.mrd  = legal & is_ld;
    dec.mwr  = legal & is_s;
    dec.src  = is_i | is_s | is_u;
    dec.ill  = !legal;
    dec.f3   = instruction[14:12];
    dec.f7   = instruction[31:25];
    if (rs1 == '0)
      dec.rs1v = '0;
    else if (need_to_write && reg_write_dest == rs1)
      dec.rs1v = reg_write_dest_value;
    else
      dec.rs1v = regs[rs1];
    if (rs2 == '0)
      dec.rs2v = '0;
    else if (need_to_write && reg_write_dest == rs2)
      dec.rs2v = reg_write_dest_value;
    else
      dec.rs2v = regs[rs2];
  end

  assign hazard = in_valid & out_valid & held.ld & (held.rd != '0) &
                  ((use_rs1 & (held.rd == rs1)) |
                   (use_rs2 & (held.rd == rs2)));
  assign in_ready = !rst & !flush & !hazard & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (flush | out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (need_to_write && reg_write_dest != '0) begin
      regs[reg_write_dest] <= reg_write_dest_value;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard) stall_count <= stall_count + 32'd1;
      if (flush)  flush_count <= flush_count + 32'd1;
    end
  end
`endif

  assign out_pc_value        = held.pc;
  assign first_reg           = held.rs1v;
  assign second_reg          = held.rs2v;
  assign sign_extended       = held.imm;
  assign reg_write_target    = held.rd;
  assign reg_write           = held.wr;
  assign reg_write_from_load = held.ld;
  assign is_branch           = held.br;
  assign is_jump             = held.jmp;
  assign mem_read            = held.mrd;
  assign mem_write           = held.mwr;
  assign ALU_src             = held.src;
  assign illegal             = held.ill;
  assign ALU_op_base         = held.f3;
  assign ALU_op_ext          = held.f7;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage.
// Build with DECODE_PERF_CNT_EN to also check the counters.
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] in_pc_value;
  logic        flush;
  logic        need_to_write;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_dest_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc_value;
  logic [31:0] first_reg;
  logic [31:0] second_reg;
  logic [63:0] sign_extended;
  logic [4:0]  reg_write_target;
  logic reg_write, reg_write_from_load, is_branch, is_jump;
  logic mem_read, mem_write, ALU_src, illegal;
  logic [2:0]  ALU_op_base;
  logic [6:0]  ALU_op_ext;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc_value(in_pc_value),
    .flush(flush), .need_to_write(need_to_write),
    .reg_write_dest(reg_write_dest),
    .reg_write_dest_value(reg_write_dest_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_value(out_pc_value),
    .first_reg(first_reg), .second_reg(second_reg),
    .sign_extended(sign_extended),
    .reg_write_target(reg_write_target),
    .reg_write(reg_write),
    .reg_write_from_load(reg_write_from_load),
    .is_branch(is_branch), .is_jump(is_jump),
    .mem_read(mem_read), .mem_write(mem_write),
    .ALU_src(ALU_src), .illegal(illegal),
    .ALU_op_base(ALU_op_base),
`ifdef DECODE_PERF_CNT_EN
    .ALU_op_ext(ALU_op_ext),
    .stall_count(stall_count),
    .flush_count(flush_count)
`else
    .ALU_op_ext(ALU_op_ext)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instruction = 32'hFFB00093;
    in_pc_value = 32'h40; flush = 1'b0; need_to_write = 1'b0;
    reg_write_dest = '0; reg_write_dest_value = '0; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({sign_extended, first_reg, reg_write_target, reg_write} !== '0)
      begin failures++;
      $display("FAIL reset_fields imm=%h rs1=%h rd=%0d",
               sign_extended, first_reg, reg_write_target); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1'b1; instruction = 32'hFFB00093; in_pc_value = 32'h100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++;
      $display("FAIL addi_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sign_extended !== 64'hFFFF_FFFF_FFFF_FFFB)
      begin failures++;
      $display("FAIL addi_imm v=%b got=%h exp=fffffffffffffffb",
               out_valid, sign_extended); end
    checks++;
    if ({ALU_src, reg_write, illegal, reg_write_target} !== {3'b110, 5'd1})
      begin failures++;
      $display("FAIL addi_ctrl src=%b wr=%b ill=%b rd=%0d exp 1,1,0,1",
               ALU_src, reg_write, illegal, reg_write_target); end
    checks++;
    if (out_pc_value !== 32'h100) begin failures++;
      $display("FAIL addi_pc got=%h exp=100", out_pc_value); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL addi_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; instruction = 32'h00012283; in_pc_value = 32'h200;
    tick();
    instruction = 32'h00128333; in_pc_value = 32'h204;
    checks++;
    if ({out_valid, reg_write_from_load, mem_read, reg_write_target}
        !== {3'b111, 5'd5}) begin failures++;
      $display("FAIL lw_held v=%b ld=%b mr=%b rd=%0d exp 1,1,1,5",
               out_valid, reg_write_from_load, mem_read, reg_write_target); end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++;
      $display("FAIL lu_refuse in_ready=%b exp=0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL lu_bubble out_valid=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++;
      $display("FAIL lu_accept in_ready=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, reg_write_target, out_pc_value} !== {1'b1, 5'd6, 32'h204})
      begin failures++;
      $display("FAIL lu_add v=%b rd=%0d pc=%h exp 1,6,204",
               out_valid, reg_write_target, out_pc_value); end
    tick();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; instruction = 32'h004183B3; in_pc_value = 32'h300;
    need_to_write = 1'b1; reg_write_dest = 5'd3;
    reg_write_dest_value = 32'h1234;
    tick();
    in_valid = 1'b0; reg_write_dest = 5'd4; reg_write_dest_value = 32'h55;
    checks++;
    if (first_reg !== 32'h1234 || second_reg !== 32'h0) begin failures++;
      $display("FAIL bypass_wt rs1=%h rs2=%h exp 1234,0",
               first_reg, second_reg); end
    tick();
    in_valid = 1'b1; need_to_write = 1'b0;
    tick();
    checks++;
    if (first_reg !== 32'h1234 || second_reg !== 32'h55) begin failures++;
      $display("FAIL bypass_rf rs1=%h rs2=%h exp 1234,55",
               first_reg, second_reg); end
    instruction = 32'h00300433;
    need_to_write = 1'b1; reg_write_dest = 5'd0;
    reg_write_dest_value = 32'hDEAD;
    tick();
    in_valid = 1'b0; need_to_write = 1'b0;
    checks++;
    if (first_reg !== 32'h0 || second_reg !== 32'h1234) begin failures++;
      $display("FAIL bypass_x0 rs1=%h rs2=%h exp 0,1234",
               first_reg, second_reg); end
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; instruction = 32'h00700113; in_pc_value = 32'h400;
    tick();
    out_ready = 1'b0; instruction = 32'h00900193; in_pc_value = 32'h404;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++;
        $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tick();
      checks++;
      if ({out_valid, reg_write_target, sign_extended, out_pc_value}
          !== {1'b1, 5'd2, 64'd7, 32'h400}) begin failures++;
        $display("FAIL stall_hold cyc=%0d v=%b rd=%0d imm=%h pc=%h",
                 i, out_valid, reg_write_target, sign_extended,
                 out_pc_value); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++;
      $display("FAIL stall_release in_ready=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, reg_write_target, sign_extended} !== {1'b1, 5'd3, 64'd9})
      begin failures++;
      $display("FAIL stall_next v=%b rd=%0d imm=%h exp 1,3,9",
               out_valid, reg_write_target, sign_extended); end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; instruction = 32'h00700113; in_pc_value = 32'h500;
    tick();
    out_ready = 1'b0; flush = 1'b1; instruction = 32'h00900193;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++;
      $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL flush_kill out_valid=%b exp=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++;
      $display("FAIL flush_drop out_valid=%b exp=0", out_valid); end
`ifdef DECODE_PERF_CNT_EN
    checks++;
    if (flush_count !== 32'd1 || stall_count !== 32'd1) begin failures++;
      $display("FAIL perf_cnt flush=%0d stall=%0d exp 1,1",
               flush_count, stall_count); end
`endif
  endtask

  task automatic test_branch_illegal();
    in_valid = 1'b1; instruction = 32'hFE000EE3; in_pc_value = 32'h600;
    tick();
    instruction = 32'h0000007F;
    checks++;
    if ({is_branch, reg_write, ALU_src, is_jump} !== 4'b1000 ||
        sign_extended !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++;
      $display("FAIL beq br=%b wr=%b src=%b j=%b imm=%h",
               is_branch, reg_write, ALU_src, is_jump, sign_extended); end
    tick();
    instruction = 32'h0000037F;
    checks++;
    if ({illegal, reg_write} !== 2'b10 || sign_extended !== 64'd0)
      begin failures++;
      $display("FAIL ill_7f ill=%b wr=%b imm=%h exp 1,0,0",
               illegal, reg_write, sign_extended); end
    tick();
    instruction = 32'h123450B7;
    checks++;
    if ({illegal, reg_write, mem_read, mem_write, reg_write_target}
        !== {4'b1000, 5'd6}) begin failures++;
      $display("FAIL ill_rd ill=%b wr=%b mr=%b mw=%b rd=%0d exp 1,0,0,0,6",
               illegal, reg_write, mem_read, mem_write, reg_write_target); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (sign_extended !== 64'h0000_0000_1234_5000 ||
        {ALU_src, reg_write, illegal} !== 3'b110) begin failures++;
      $display("FAIL lui imm=%h src=%b wr=%b ill=%b exp 12345000,1,1,0",
               sign_extended, ALU_src, reg_write, illegal); end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_stall();
    test_flush();
    test_branch_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_decode_stage.md
Name: pipelined_decode_stage

Overview:
- Next-generation ID stage: decodes one RV32 instruction per cycle into a registered ID/EX bundle with valid/ready handshakes on both sides.
- Contains the integer register file with write-through bypass and per-format immediate generation.
- Detects load-use hazards and inserts one bubble. Accepts a flush from branch resolution.
- Sits between the IF stage and the EX stage.

Parameters:
XLEN, 32, register/operand/PC width
IMM_WIDTH, 64, sign-extended immediate width (must be >= XLEN)
NUM_REGS, 32, architectural registers; index width REG_AW = clog2(NUM_REGS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  IF bundle valid
in_ready  out  1  stage can accept this cycle
instruction  in  32  raw instruction
in_pc_value  in  XLEN  PC of instruction
flush  in  1  kill held and incoming instruction
need_to_write  in  1  WB write enable
reg_write_dest  in  REG_AW  WB destination
reg_write_dest_value  in  XLEN  WB data
out_valid  out  1  ID/EX bundle valid
out_ready  in  1  EX accepts bundle
out_pc_value  out  XLEN  registered PC
first_reg, second_reg  out  XLEN  rs1/rs2 operands
sign_extended  out  IMM_WIDTH  decoded immediate
reg_write_target  out  REG_AW  rd
reg_write, reg_write_from_load, is_branch, is_jump, mem_read, mem_write, ALU_src, illegal  out  1 each  control
ALU_op_base  out  3  funct3
ALU_op_ext  out  7  funct7

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0; every output field = 0.
  - All registers cleared to 0.
  - in_ready = 0 during the reset cycle.
- Handshake:
  - hazard = in_valid & out_valid & reg_write_from_load(held) & (reg_write_target != 0) & (held rd == rs1 or held rd == rs2).
  - rs2 is compared only for R, S and B formats; rs1 is not compared for U and J formats.
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - Accept on in_valid & in_ready: output register loads the decoded bundle; out_valid <= 1 next edge. Latency is 1 cycle.
  - If out_ready & out_valid and nothing is accepted, out_valid <= 0.
  - While out_valid & !out_ready, all outputs hold stable.
- Load-use bubble:
  - In the hazard cycle the load may leave (out_ready=1). The dependent instruction is refused.
  - The next cycle shows out_valid=0 (one bubble); the dependent instruction is accepted that cycle.
- Flush has top priority: out_valid <= 0 next edge and no acceptance in that cycle, regardless of out_ready or hazard.
- Register file:
  - Written on need_to_write & reg_write_dest != 0 every cycle, independent of stall and flush.
  - x0 always reads 0.
  - Read is combinational at acceptance. Write-through: if need_to_write & reg_write_dest == rs & rs != 0, the operand is reg_write_dest_value in the same cycle.
- Immediate selection by opcode, sign-extended from bit 31 to IMM_WIDTH:
  - I-format: 0010011, 0000011, 1100111.
  - S-format: 0100011.
  - B-format: 1100011.
  - U-format: 0110111, 0010111 (low 12 bits 0).
  - J-format: 1101111.
  - Otherwise 0.
- Control:
  - reg_write = 1 for 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, and only when rd != 0.
  - reg_write_from_load = (opcode == 0000011).
  - mem_read = load; mem_write = (opcode == 0100011).
  - is_branch = (opcode == 1100011); is_jump = 1101111 or 1100111.
  - ALU_src = 1 for I-format, S-format and U-format opcodes.
  - ALU_op_base = funct3; ALU_op_ext = funct7.
- Illegal instructions:
  - illegal = 1 if the opcode is not in the set above plus 0100011, 1100011, 1110011, 0001111, or if instruction[1:0] != 11.
  - An illegal bundle passes with reg_write, mem_read and mem_write forced to 0.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Enabled: adds outputs stall_count (32 bits) and flush_count (32 bits).
  - stall_count increments on each cycle with in_valid & hazard.
  - flush_count increments on each flush cycle.
  - Both are cleared by rst and wrap at 2^32.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ADDI x1,x0,-5 (0xFFB00093) with in_valid=1, out_ready=1 → next cycle out_valid=1, sign_extended=0xFFFF_FFFF_FFFF_FFFB, ALU_src=1, reg_write=1, reg_write_target=1.
- LW x5,0(x2) followed by ADD x6,x5,x1 (out_ready=1) → ADD refused for 1 cycle (in_ready=0), one bubble (out_valid=0), ADD emitted 2 cycles after the LW.
- ADD x7,x3,x4 with need_to_write=1, reg_write_dest=3, reg_write_dest_value=0x1234 in the same cycle → first_reg=0x1234.
- out_ready=0 for 3 cycles with a valid bundle held → outputs stable, in_ready=0; release → bundle consumed, next instruction accepted.
- flush=1 while a bundle is held and in_valid=1 → out_valid=0 next cycle, incoming dropped. With DECODE_PERF_CNT_EN, flush_count=1.
- BEQ with imm=-4 (0xFE000EE3) → is_branch=1, reg_write=0, sign_extended=-4. Instruction 0x0000007F → illegal=1, reg_write=0.
